// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART TX path and its RTS/CTS handshake
// between NUM_REQ byte-stream requesters, granting whole frames at a time.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int GAP_CYCLES  = 16,
  parameter int CTS_TIMEOUT = 1024
) (
  input  logic                      tck,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_rts_n,
  input  logic                      tx_cts_n,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      timeout_err
);

  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_MAX = (GAP_CYCLES > CTS_TIMEOUT) ? GAP_CYCLES : CTS_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] CTS_LAST = CNT_W'(CTS_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, XFER, GAP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   gidx;
  logic [IDX_W-1:0]   last_grant;
  logic [CNT_W-1:0]   cnt;

  logic [DATA_W-1:0]  req_bytes [NUM_REQ];
  logic               sel_found;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   cand;
  logic               in_xfer;
  logic               cts_ok;
  logic               xfer_fire;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_bytes[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Search upward from the requester after the last winner, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((int'(last_grant) + off) % NUM_REQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Byte handshake is a combinational pass-through gated by state and CTS.
  assign in_xfer   = (state == XFER);
  assign cts_ok    = ~tx_cts_n;
  assign tx_valid  = in_xfer & req_valid[gidx] & cts_ok;
  assign tx_data   = in_xfer ? req_bytes[gidx] : '0;
  assign req_ready = grant & {NUM_REQ{in_xfer & tx_ready & cts_ok}};
  assign xfer_fire = tx_valid & tx_ready;
  assign busy      = (state != IDLE);

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      grant       <= '0;
      gidx        <= '0;
      last_grant  <= IDX_W'(NUM_REQ - 1);
      tx_rts_n    <= 1'b1;
      timeout_err <= 1'b0;
      cnt         <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && sel_found) begin
            grant      <= {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx;
            gidx       <= sel_idx;
            last_grant <= sel_idx;
            tx_rts_n   <= 1'b0;
            cnt        <= '0;
            state      <= REQ;
          end
        end
        REQ: begin
          if (!tx_cts_n) begin
            cnt   <= '0;
            state <= XFER;
          end else if (cnt == CTS_LAST) begin
            timeout_err <= 1'b1;
            tx_rts_n    <= 1'b1;
            grant       <= '0;
            cnt         <= '0;
            state       <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        XFER: begin
          if (xfer_fire && req_last[gidx]) begin
            tx_rts_n <= 1'b1;
            grant    <= '0;
            cnt      <= '0;
            state    <= GAP;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit path, and its RTS/CTS flow-control handshake, between NUM_REQ byte-stream requesters.
- Grants whole frames in round-robin order and raises local RTS while a grant is held.
- Passes bytes only while the flow-control logic reports CTS, then holds a programmable turnaround gap before re-arbitrating.
- Sits between client streams and the flow-control/TX logic (drives its tx_rts_n, consumes its tx_cts_n).

Parameters:
- NUM_REQ, 4: number of requesters (2..8).
- DATA_W, 8: byte width.
- GAP_CYCLES, 16: idle turnaround cycles after each frame or timeout (0 allowed).
- CTS_TIMEOUT, 1024: cycles in REQ state waiting for CTS before abort (>=2).

Ports:
- tck  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  arbitration enable; sampled only in IDLE
- req_valid  in  NUM_REQ  per-requester byte valid
- req_data  in  NUM_REQ*DATA_W  per-requester byte; requester i uses bits [i*DATA_W +: DATA_W]
- req_last  in  NUM_REQ  byte is last of frame
- req_ready  out  NUM_REQ  byte accepted when valid&ready
- tx_rts_n  out  1  local request-to-send toward flow control, active low
- tx_cts_n  in  1  clear-to-send from flow control, active low
- tx_data  out  DATA_W  byte to UART TX
- tx_valid  out  1  byte valid to UART TX
- tx_ready  in  1  UART TX accepts byte
- grant  out  NUM_REQ  one-hot current owner, 0 when none
- busy  out  1  state != IDLE
- timeout_err  out  1  one-cycle pulse on CTS timeout

Behaviour:
- Reset values:
  - state=IDLE, grant=0, tx_rts_n=1, timeout_err=0, busy=0, counter=0.
  - RR pointer set so requester 0 has highest priority.
  - Reset applies immediately mid-frame; a partial frame is abandoned.
- States: IDLE, REQ, XFER, GAP.
- IDLE:
  - If enable and any req_valid, select the first valid requester searching upward (wrapping) from last_grant+1.
  - Register grant and enter REQ next cycle; tx_rts_n goes low in that same cycle (registered).
  - last_grant updates at grant time.
  - With no valid requesters, stay in IDLE and keep outputs quiet.
- REQ:
  - tx_rts_n=0; counter increments each cycle.
  - If tx_cts_n==0, go to XFER; counter clears.
  - Else if counter==CTS_TIMEOUT-1: pulse timeout_err for 1 cycle, tx_rts_n=1, grant cleared, go to GAP.
  - The requester is not flushed; it competes again after GAP.
- XFER:
  - tx_rts_n=0.
  - tx_valid = req_valid[g] & ~tx_cts_n; tx_data = req_data[g]; req_ready[g] = tx_ready & ~tx_cts_n.
  - All other req_ready are 0.
  - Handshake is combinational pass-through, so each accepted byte has zero added latency.
  - If tx_cts_n rises mid-frame, transfers stall (tx_valid=0, req_ready=0) with the grant held. There is no timeout in XFER.
  - A transfer with req_last=1 moves to GAP next cycle; tx_rts_n=1 and grant=0 from that cycle.
- GAP:
  - Counter runs 0..GAP_CYCLES-1, then IDLE.
  - GAP_CYCLES=0: GAP lasts exactly 1 cycle.
  - tx_rts_n=1, all ready=0.
- enable deasserted outside IDLE has no effect; the current frame completes.
- Outside XFER: tx_valid=0, req_ready=0, tx_data=0.
- grant is one-hot or zero at all times.
- Counter width is clog2(max(GAP_CYCLES, CTS_TIMEOUT))+1. There is no wrap in normal operation.

Test Plan:
- Single requester:
  - Stimulus: req 1 sends a 3-byte frame (0xA1, 0xA2, 0xA3 last); tx_cts_n is driven low 2 cycles after tx_rts_n falls; tx_ready=1.
  - Response: grant=0010; three consecutive tx_valid beats with the correct data; tx_rts_n rises the cycle after 0xA3; GAP lasts 16 cycles; busy=0 afterwards.
- Round-robin fairness:
  - Stimulus: all 4 requesters continuously valid, 1-byte frames, CTS always low.
  - Response: grant order 0,1,2,3,0,... with a GAP between each frame.
- CTS timeout:
  - Stimulus: requester 2 valid, tx_cts_n held high.
  - Response: timeout_err pulses exactly once, 1024 cycles after REQ entry; tx_rts_n=1; no bytes passed; requester 2 is re-granted after GAP.
- Mid-frame CTS drop:
  - Stimulus: tx_cts_n goes high for 5 cycles after byte 1 of a 4-byte frame.
  - Response: no tx_valid or req_ready during those cycles; grant unchanged; the remaining 3 bytes complete in order.
- Backpressure and enable:
  - Stimulus: tx_ready toggles every cycle; enable drops mid-frame.
  - Response: bytes transfer only on valid&ready cycles; the frame completes; no new grant occurs while enable=0.
- Async reset mid-XFER:
  - Stimulus: assert rst_n=0 during XFER.
  - Response: tx_rts_n=1, grant=0, tx_valid=0 immediately; after release, requester 0 is granted first.
